ex_muldiv_unit: RTL



---
 rtl/ex_muldiv_unit_pkg.sv | 35 +++
 rtl/ex_muldiv_unit_if.sv | 28 ++
 rtl/ex_muldiv_unit_step.sv | 39 +++
 rtl/ex_muldiv_unit.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit:
// opcode and FSM encodings, default width and the divide-by-zero quotient.
package muldiv_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    OP_NONE   = 3'd0,
    OP_MULT   = 3'd1,
    OP_MULTU  = 3'd2,
    OP_DIV    = 3'd3,
    OP_DIVU   = 3'd4,
    OP_MTHI   = 3'd5,
    OP_MTLO   = 3'd6,
    OP_MFHILO = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  localparam logic [DATA_W_DEF-1:0] DIV0_QUOT = {DATA_W_DEF{1'b1}};

  function automatic logic is_muldiv(input op_e op);
    logic r;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-side bundle for the multiply/divide unit: instruction inputs from the
// pipeline register and the status/HI/LO outputs back to the pipeline.
interface ex_muldiv_unit_if #(
  parameter int DATA_W = muldiv_pkg::DATA_W_DEF
);

  logic              valid_in;
  logic [2:0]        op_in;
  logic [DATA_W-1:0] rs_in;
  logic [DATA_W-1:0] rt_in;
  logic              flush_in;
  logic              stall_out;
  logic              busy_out;
  logic              done_out;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;

  modport master (
    output valid_in, op_in, rs_in, rt_in, flush_in,
    input  stall_out, busy_out, done_out, hi_out, lo_out
  );

  modport slave (
    input  valid_in, op_in, rs_in, rt_in, flush_in,
    output stall_out, busy_out, done_out, hi_out, lo_out
  );

endinterface

// File: rtl/ex_muldiv_unit_step.sv
// One unsigned iteration: shift-add multiply (acc:opr shifts right) or
// restoring divide (acc:opr shifts left, quotient bit enters at opr[0]).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] i_acc,
  input  logic [DATA_W-1:0] i_opr,
  input  logic [DATA_W-1:0] i_oth,
  input  logic              i_div,
  output logic [DATA_W-1:0] o_acc,
  output logic [DATA_W-1:0] o_opr
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_rsh;
  logic [DATA_W:0] w_diff;

  // Both candidate iterations are formed; mode picks which one advances.
  always_comb begin
    w_sum  = {1'b0, i_acc} + (i_opr[0] ? {1'b0, i_oth} : {(DATA_W+1){1'b0}});
    w_rsh  = {i_acc, i_opr[DATA_W-1]};
    w_diff = w_rsh - {1'b0, i_oth};
    if (i_div) begin
      if (w_diff[DATA_W]) begin
        o_acc = w_rsh[DATA_W-1:0];
        o_opr = {i_opr[DATA_W-2:0], 1'b0};
      end else begin
        o_acc = w_diff[DATA_W-1:0];
        o_opr = {i_opr[DATA_W-2:0], 1'b1};
      end
    end else begin
      o_acc = w_sum[DATA_W:1];
      o_opr = {w_sum[0], i_opr[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU engine owning HI/LO, with MTHI/MTLO
// service and a stall request for HI/LO users while an operation is in flight.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input logic             clk,
  input logic             rst,
  ex_muldiv_unit_if.slave bus
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  L_LAST   = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] L_DIV0_Q = {DATA_W{DIV0_QUOT[0]}};

  state_e              r_state;
  logic [CNT_W-1:0]    r_count;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   r_opr;
  logic [DATA_W-1:0]   r_oth;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_is_div;
  logic                r_neg_a;
  logic                r_neg_b;
  logic                r_busy;
  logic                r_done;

  op_e                 w_op;
  logic                w_live;
  logic                w_start;
  logic                w_is_div;
  logic                w_signed;
  logic                w_neg_a;
  logic                w_neg_b;
  logic [DATA_W-1:0]   w_mag_a;
  logic [DATA_W-1:0]   w_mag_b;
  logic [DATA_W-1:0]   w_acc_n;
  logic [DATA_W-1:0]   w_opr_n;
  logic [DATA_W-1:0]   w_hi_fix;
  logic [DATA_W-1:0]   w_lo_fix;
  logic [2*DATA_W-1:0] w_prod;

  assign w_op   = op_e'(bus.op_in);
  assign w_live = bus.valid_in & ~bus.flush_in;

  // Operand decode: magnitudes and sign flags latched on accept.
  always_comb begin
    w_start  = w_live & is_muldiv(w_op);
    w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
    w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
    w_neg_a  = w_signed & bus.rs_in[DATA_W-1];
    w_neg_b  = w_signed & bus.rt_in[DATA_W-1];
    w_mag_a  = w_neg_a ? -bus.rs_in : bus.rs_in;
    w_mag_b  = w_neg_b ? -bus.rt_in : bus.rt_in;
  end

  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .i_acc (r_acc),
    .i_opr (r_opr),
    .i_oth (r_oth),
    .i_div (r_is_div),
    .o_acc (w_acc_n),
    .o_opr (w_opr_n)
  );

  // Sign correction. A zero divisor leaves the dividend magnitude in acc, so
  // the remainder path already restores rs as latched; only LO is overridden.
  always_comb begin
    w_prod = {r_acc, r_opr};
    if (r_is_div) begin
      w_hi_fix = r_neg_a ? -r_acc : r_acc;
      if (r_oth == {DATA_W{1'b0}}) begin
        w_lo_fix = L_DIV0_Q;
      end else if (r_neg_a ^ r_neg_b) begin
        w_lo_fix = -r_opr;
      end else begin
        w_lo_fix = r_opr;
      end
    end else begin
      {w_hi_fix, w_lo_fix} = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
    end
  end

  // Control FSM, iteration datapath and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_count  <= {CNT_W{1'b0}};
      r_acc    <= {DATA_W{1'b0}};
      r_opr    <= {DATA_W{1'b0}};
      r_oth    <= {DATA_W{1'b0}};
      r_hi     <= {DATA_W{1'b0}};
      r_lo     <= {DATA_W{1'b0}};
      r_is_div <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_acc    <= {DATA_W{1'b0}};
            r_opr    <= w_is_div ? w_mag_a : w_mag_b;
            r_oth    <= w_is_div ? w_mag_b : w_mag_a;
            r_is_div <= w_is_div;
            r_neg_a  <= w_neg_a;
            r_neg_b  <= w_neg_b;
            r_count  <= {CNT_W{1'b0}};
            r_busy   <= 1'b1;
            r_state  <= ST_BUSY;
          end else if (w_live && (w_op == OP_MTHI)) begin
            r_hi <= bus.rs_in;
          end else if (w_live && (w_op == OP_MTLO)) begin
            r_lo <= bus.rs_in;
          end
        end
        ST_BUSY: begin
          if (bus.flush_in) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_acc   <= w_acc_n;
            r_opr   <= w_opr_n;
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            if (r_count == L_LAST) begin
              r_state <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          if (!bus.flush_in) begin
            r_hi   <= w_hi_fix;
            r_lo   <= w_lo_fix;
            r_done <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.stall_out = bus.valid_in & (w_op != OP_NONE) & (r_state != ST_IDLE) & ~bus.flush_in;
  assign bus.busy_out  = r_busy;
  assign bus.done_out  = r_done;
  assign bus.hi_out    = r_hi;
  assign bus.lo_out    = r_lo;

endmodule
